frv_pipeline_flush_ctrl: RTL and testbench

Sequencer for the core's chain of pipeline stage registers. Turns trap, branch and fence.i requests into per-register flush strobes. Issues a held redirect to fetch and stalls stage 0 until fetch accepts it. Sits between the execute/writeback stages and the pipeline register chain plus the fetch unit.

---
 rtl/frv_pipe_ctrl_pkg.sv | 31 +++
 rtl/frv_pipeline_flush_ctrl.sv | 165 ++++++++++++++++
 tb/tb_frv_pipeline_flush_ctrl.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/frv_pipe_ctrl_pkg.sv
// Shared types and helpers for the pipeline flush controller.
package frv_pipe_ctrl_pkg;

    localparam int unsigned MASK_W = 32;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REDIRECT = 2'd1,
        DRAIN    = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        TRAP   = 2'd0,
        BRANCH = 2'd1,
        FENCEI = 2'd2
    } cause_e;

    // Flush mask covering the stage registers younger than ex_stage.
    function automatic logic [MASK_W-1:0] young_mask(input int unsigned nstages,
                                                     input int unsigned ex_stage);
        logic [MASK_W-1:0] m;
        m = '0;
        for (int unsigned i = 0; i < MASK_W; i++) begin
            if ((i < ex_stage) && (i < nstages)) begin
                m[i] = 1'b1;
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/frv_pipeline_flush_ctrl.sv
// Pipeline flush sequencer: turns trap/branch/fence.i requests into per-stage
// flush strobes, a held fetch redirect and a fence.i drain handshake.
// Optional FRV_FLUSH_COUNT_EN adds a free-running count of flush cycles on
// flush_count; without it the port is tied to zero.
module frv_pipeline_flush_ctrl
    import frv_pipe_ctrl_pkg::*;
#(
    parameter int unsigned NSTAGES  = 5,
    parameter int unsigned EX_STAGE = 2,
    parameter int unsigned XLEN     = 32
) (
    input  logic               g_clk,
    input  logic               g_reset,
    input  logic [NSTAGES-1:0] s_valid,
    input  logic               trap_req,
    input  logic [XLEN-1:0]    trap_addr,
    input  logic               branch_req,
    input  logic [XLEN-1:0]    branch_addr,
    input  logic               fencei_req,
    input  logic [XLEN-1:0]    fencei_addr,
    output logic [NSTAGES-1:0] flush,
    output logic               hold,
    output logic               redir_valid,
    output logic [XLEN-1:0]    redir_addr,
    input  logic               redir_ack,
    output logic               fencei_done,
    output logic [31:0]        flush_count
);

    localparam int unsigned       CNT_W      = 32;
    localparam logic [MASK_W-1:0] YOUNG_FULL = young_mask(NSTAGES, EX_STAGE);
    localparam logic [NSTAGES-1:0] YOUNG_MASK = YOUNG_FULL[NSTAGES-1:0];
    localparam logic [NSTAGES-1:0] ALL_MASK   = '1;

    state_e             state_q, state_d;
    logic [NSTAGES-1:0] flush_q, flush_d;
    logic               hold_q, hold_d;
    logic               redir_valid_q, redir_valid_d;
    logic [XLEN-1:0]    redir_addr_q, redir_addr_d;
    logic               fencei_done_q, fencei_done_d;

    cause_e             req_cause_c;
    logic               req_any_c;
    logic               drained_c;
    logic               unused_s_valid;

    // Only stages older than EX_STAGE matter for the fence.i drain.
    assign drained_c      = (s_valid[NSTAGES-1:EX_STAGE+1] == '0);
    assign unused_s_valid = ^s_valid[EX_STAGE:0];

    // Request arbitration: trap > branch > fence.i.
    always_comb begin
        req_any_c   = trap_req | branch_req | fencei_req;
        req_cause_c = FENCEI;
        if (trap_req) begin
            req_cause_c = TRAP;
        end else if (branch_req) begin
            req_cause_c = BRANCH;
        end
    end

    // Next-state and registered-output decode.
    always_comb begin
        state_d       = state_q;
        flush_d       = '0;
        redir_addr_d  = redir_addr_q;
        fencei_done_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_any_c) begin
                    case (req_cause_c)
                        TRAP: begin
                            state_d      = REDIRECT;
                            flush_d      = ALL_MASK;
                            redir_addr_d = trap_addr;
                        end
                        BRANCH: begin
                            state_d      = REDIRECT;
                            flush_d      = YOUNG_MASK;
                            redir_addr_d = branch_addr;
                        end
                        default: begin
                            state_d      = DRAIN;
                            flush_d      = YOUNG_MASK;
                            redir_addr_d = fencei_addr;
                        end
                    endcase
                end
            end
            REDIRECT: begin
                // An older faulting instruction re-targets the redirect, even over an ack.
                if (trap_req) begin
                    flush_d      = ALL_MASK;
                    redir_addr_d = trap_addr;
                end else if (redir_ack && redir_valid_q) begin
                    state_d = IDLE;
                end
            end
            DRAIN: begin
                if (trap_req) begin
                    state_d      = REDIRECT;
                    flush_d      = ALL_MASK;
                    redir_addr_d = trap_addr;
                end else if (drained_c) begin
                    state_d       = REDIRECT;
                    fencei_done_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        redir_valid_d = (state_d == REDIRECT);
        hold_d        = (state_d != IDLE) || (flush_d != '0);
    end

    // State and output registers.
    always_ff @(posedge g_clk) begin
        if (g_reset) begin
            state_q       <= IDLE;
            flush_q       <= '0;
            hold_q        <= 1'b0;
            redir_valid_q <= 1'b0;
            redir_addr_q  <= '0;
            fencei_done_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            flush_q       <= flush_d;
            hold_q        <= hold_d;
            redir_valid_q <= redir_valid_d;
            redir_addr_q  <= redir_addr_d;
            fencei_done_q <= fencei_done_d;
        end
    end

    assign flush       = flush_q;
    assign hold        = hold_q;
    assign redir_valid = redir_valid_q;
    assign redir_addr  = redir_addr_q;
    assign fencei_done = fencei_done_q;

    generate
        if (1) begin : g_flush_cnt
`ifdef FRV_FLUSH_COUNT_EN
            logic [CNT_W-1:0] count_q;

            // Count cycles in which any flush strobe is driven; wraps naturally.
            always_ff @(posedge g_clk) begin
                if (g_reset) begin
                    count_q <= '0;
                end else if (flush_q != '0) begin
                    count_q <= count_q + CNT_W'(1);
                end
            end

            assign flush_count = count_q;
`else
            assign flush_count = CNT_W'(0);
`endif
        end
    endgenerate

endmodule

// File: tb/tb_frv_pipeline_flush_ctrl.sv
// Self-checking bench for frv_pipeline_flush_ctrl (NSTAGES=5, EX_STAGE=2).
module tb_frv_pipeline_flush_ctrl;

    localparam int unsigned NS = 5;
    localparam int unsigned XL = 32;
    localparam logic [XL-1:0] TA = 32'h0000_0040;
    localparam logic [XL-1:0] FA = 32'h2000_0004;
    localparam logic [XL-1:0] BA = 32'h8000_0100;

    logic          g_clk;
    logic          g_reset;
    logic [NS-1:0] s_valid;
    logic          trap_req;
    logic [XL-1:0] trap_addr;
    logic          branch_req;
    logic [XL-1:0] branch_addr;
    logic          fencei_req;
    logic [XL-1:0] fencei_addr;
    logic [NS-1:0] flush;
    logic          hold;
    logic          redir_valid;
    logic [XL-1:0] redir_addr;
    logic          redir_ack;
    logic          fencei_done;
    logic [31:0]   flush_count;

    frv_pipeline_flush_ctrl #(.NSTAGES(NS), .EX_STAGE(2), .XLEN(XL)) dut (
        .g_clk       (g_clk),
        .g_reset     (g_reset),
        .s_valid     (s_valid),
        .trap_req    (trap_req),
        .trap_addr   (trap_addr),
        .branch_req  (branch_req),
        .branch_addr (branch_addr),
        .fencei_req  (fencei_req),
        .fencei_addr (fencei_addr),
        .flush       (flush),
        .hold        (hold),
        .redir_valid (redir_valid),
        .redir_addr  (redir_addr),
        .redir_ack   (redir_ack),
        .fencei_done (fencei_done),
        .flush_count (flush_count)
    );

    initial g_clk = 1'b0;
    always #5 g_clk = ~g_clk;

    typedef struct {
        logic          rst;
        logic [NS-1:0] sv;
        logic          trap;
        logic          br;
        logic [XL-1:0] ba;
        logic          fi;
        logic          ack;
        logic [NS-1:0] fl;
        logic          hd;
        logic          rv;
        logic [XL-1:0] ra;
        logic          fd;
    } vec_t;

    typedef struct {
        logic [NS-1:0] fl;
        logic          hd;
        logic          rv;
        logic [XL-1:0] ra;
        logic          fd;
    } exp_t;

    vec_t vecs[$];
    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    function automatic vec_t mk(logic rst, logic [NS-1:0] sv, logic trap, logic br,
                                logic [XL-1:0] ba, logic fi, logic ack,
                                logic [NS-1:0] fl, logic hd, logic rv,
                                logic [XL-1:0] ra, logic fd);
        vec_t v;
        v.rst = rst; v.sv = sv; v.trap = trap; v.br = br; v.ba = ba; v.fi = fi;
        v.ack = ack; v.fl = fl; v.hd = hd; v.rv = rv; v.ra = ra; v.fd = fd;
        return v;
    endfunction

    // Drive one cycle of inputs on the falling edge, then wait past the rising edge.
    task automatic drive(input logic rst, input logic [NS-1:0] sv, input logic trap,
                         input logic br, input logic [XL-1:0] ba, input logic fi,
                         input logic ack);
        @(negedge g_clk);
        g_reset     = rst;
        s_valid     = sv;
        trap_req    = trap;
        trap_addr   = TA;
        branch_req  = br;
        branch_addr = ba;
        fencei_req  = fi;
        fencei_addr = FA;
        redir_ack   = ack;
        @(posedge g_clk);
        #1;
    endtask

    task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    initial begin
        exp_t e;
        int   n;
        int   done_cnt;
        int   done_cyc;
        int   hold_low;

        g_reset = 1'b1; s_valid = '0; trap_req = 1'b0; trap_addr = '0;
        branch_req = 1'b0; branch_addr = '0; fencei_req = 1'b0; fencei_addr = '0;
        redir_ack = 1'b0;

        //              rst sv        trp br  ba            fi  ack  flush     hd  rv  ra            fd
        vecs.push_back(mk(1, 5'b00000, 0, 0, 32'h0,        0, 0, 5'b00000, 0, 0, 32'h0,        0));
        vecs.push_back(mk(0, 5'b00000, 0, 0, 32'h0,        0, 0, 5'b00000, 0, 0, 32'h0,        0));
        // branch redirect, ack three cycles later
        vecs.push_back(mk(0, 5'b00000, 0, 1, BA,           0, 0, 5'b00011, 1, 1, BA,           0));
        vecs.push_back(mk(0, 5'b00000, 0, 0, 32'h0,        0, 0, 5'b00000, 1, 1, BA,           0));
        vecs.push_back(mk(0, 5'b00000, 0, 0, 32'h0,        0, 0, 5'b00000, 1, 1, BA,           0));
        vecs.push_back(mk(0, 5'b00000, 0, 0, 32'h0,        0, 1, 5'b00000, 0, 0, BA,           0));
        vecs.push_back(mk(0, 5'b00000, 0, 0, 32'h0,        0, 1, 5'b00000, 0, 0, BA,           0));
        // all three requests together: trap wins
        vecs.push_back(mk(0, 5'b00000, 1, 1, BA,           1, 0, 5'b11111, 1, 1, TA,           0));
        vecs.push_back(mk(0, 5'b00000, 0, 0, 32'h0,        0, 1, 5'b00000, 0, 0, TA,           0));
        vecs.push_back(mk(0, 5'b00000, 0, 0, 32'h0,        0, 0, 5'b00000, 0, 0, TA,           0));
        // fence.i drain with older stages busy for four cycles
        vecs.push_back(mk(0, 5'b11000, 0, 0, 32'h0,        1, 0, 5'b00011, 1, 0, FA,           0));
        vecs.push_back(mk(0, 5'b11000, 0, 0, 32'h0,        0, 0, 5'b00000, 1, 0, FA,           0));
        vecs.push_back(mk(0, 5'b11000, 0, 0, 32'h0,        0, 0, 5'b00000, 1, 0, FA,           0));
        vecs.push_back(mk(0, 5'b11000, 0, 0, 32'h0,        0, 0, 5'b00000, 1, 0, FA,           0));
        vecs.push_back(mk(0, 5'b00000, 0, 0, 32'h0,        0, 0, 5'b00000, 1, 1, FA,           1));
        vecs.push_back(mk(0, 5'b00000, 0, 0, 32'h0,        0, 0, 5'b00000, 1, 1, FA,           0));
        vecs.push_back(mk(0, 5'b00000, 0, 0, 32'h0,        0, 1, 5'b00000, 0, 0, FA,           0));
        // trap arriving with the ack keeps REDIRECT; branch in REDIRECT ignored
        vecs.push_back(mk(0, 5'b00000, 0, 1, 32'h100,      0, 0, 5'b00011, 1, 1, 32'h100,      0));
        vecs.push_back(mk(0, 5'b00000, 1, 0, 32'h0,        0, 1, 5'b11111, 1, 1, TA,           0));
        vecs.push_back(mk(0, 5'b00000, 0, 0, 32'h0,        0, 0, 5'b00000, 1, 1, TA,           0));
        vecs.push_back(mk(0, 5'b00000, 0, 1, 32'h999,      0, 0, 5'b00000, 1, 1, TA,           0));
        vecs.push_back(mk(0, 5'b00000, 0, 0, 32'h0,        0, 1, 5'b00000, 0, 0, TA,           0));
        // reset mid-drain, stray ack afterwards
        vecs.push_back(mk(0, 5'b11111, 0, 0, 32'h0,        1, 0, 5'b00011, 1, 0, FA,           0));
        vecs.push_back(mk(1, 5'b11111, 0, 0, 32'h0,        0, 0, 5'b00000, 0, 0, 32'h0,        0));
        vecs.push_back(mk(0, 5'b00000, 0, 0, 32'h0,        0, 1, 5'b00000, 0, 0, 32'h0,        0));
        vecs.push_back(mk(0, 5'b00000, 0, 0, 32'h0,        0, 0, 5'b00000, 0, 0, 32'h0,        0));
        // trap aborts a drain: no fencei_done
        vecs.push_back(mk(0, 5'b10000, 0, 0, 32'h0,        1, 0, 5'b00011, 1, 0, FA,           0));
        vecs.push_back(mk(0, 5'b10000, 1, 0, 32'h0,        0, 0, 5'b11111, 1, 1, TA,           0));
        vecs.push_back(mk(0, 5'b00000, 0, 0, 32'h0,        0, 0, 5'b00000, 1, 1, TA,           0));
        vecs.push_back(mk(0, 5'b00000, 0, 0, 32'h0,        0, 1, 5'b00000, 0, 0, TA,           0));
        // EX_STAGE and younger occupancy does not block the drain
        vecs.push_back(mk(0, 5'b00111, 0, 0, 32'h0,        1, 0, 5'b00011, 1, 0, FA,           0));
        vecs.push_back(mk(0, 5'b00100, 0, 0, 32'h0,        0, 0, 5'b00000, 1, 1, FA,           1));
        vecs.push_back(mk(0, 5'b00000, 0, 0, 32'h0,        0, 1, 5'b00000, 0, 0, FA,           0));

        foreach (vecs[i]) begin
            e.fl = vecs[i].fl; e.hd = vecs[i].hd; e.rv = vecs[i].rv;
            e.ra = vecs[i].ra; e.fd = vecs[i].fd;
            exp_q.push_back(e);
            drive(vecs[i].rst, vecs[i].sv, vecs[i].trap, vecs[i].br, vecs[i].ba,
                  vecs[i].fi, vecs[i].ack);
            e = exp_q.pop_front();
            total++;
            if ({flush, hold, redir_valid, redir_addr, fencei_done} !==
                {e.fl, e.hd, e.rv, e.ra, e.fd}) begin
                bad++;
                $display("FAIL vec%0d: flush=%b hold=%b rv=%b addr=%h fd=%b expected flush=%b hold=%b rv=%b addr=%h fd=%b",
                         i, flush, hold, redir_valid, redir_addr, fencei_done,
                         e.fl, e.hd, e.rv, e.ra, e.fd);
            end
        end

        // Random-length drain: exactly one fencei_done, on the cycle after drain, hold throughout.
        n = $urandom_range(3, 8);
        done_cnt = 0; done_cyc = -1; hold_low = 0;
        for (int c = 0; c < n + 6; c++) begin
            drive(1'b0, (c < n) ? 5'b11000 : 5'b00000, 1'b0, 1'b0, 32'h0, (c == 0), 1'b0);
            if (fencei_done) begin
                done_cnt++;
                done_cyc = c;
            end
            if (!hold) hold_low++;
        end
        check_val("drain_done_count", 32'(done_cnt), 32'd1);
        check_val("drain_done_cycle", 32'(done_cyc), 32'(n));
        check_val("drain_hold_low",   32'(hold_low), 32'd0);
        check_val("drain_redir_addr", redir_addr, FA);
        drive(1'b0, 5'b00000, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        check_val("drain_ack_rv", 32'(redir_valid), 32'd0);

        // Flush counter: three branch redirects plus one trap.
        drive(1'b1, 5'b00000, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        check_val("count_reset", flush_count, 32'd0);
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 5'b00000, 1'b0, 1'b1, BA, 1'b0, 1'b0);
            drive(1'b0, 5'b00000, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        end
        drive(1'b0, 5'b00000, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        drive(1'b0, 5'b00000, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
`ifdef FRV_FLUSH_COUNT_EN
        check_val("flush_count", flush_count, 32'd4);
`else
        check_val("flush_count", flush_count, 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
